// File: rtl/uart_serial_rx_pkg.sv
// uart_serial_rx_pkg: shared UART receive/transmit types and helpers.
// Holds FSM encoding, frame width and the baud divider rounding rule.
package uart_serial_rx_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Rounded clocks per oversample tick; shared with the transmitter
  // so both ends derive the same divider from the same parameters.
  function automatic int calc_div(
    input int clk_freq,
    input int baud,
    input int os
  );
    longint num;
    longint den;
    den = longint'(baud) * longint'(os);
    num = longint'(clk_freq) + den / 2;
    return int'(num / den);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running oversample divider with sync clear.
// Ports: clk_i, rst_ni (async low), clr_i (restart phase), tick_o.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/uart_serial_rx.sv
// uart_serial_rx: 8N1 oversampled UART receiver, majority-vote bits.
// Ports: clk, rst (async low), rxd, rx_ack in; data_out, flags out.
import uart_serial_rx_pkg::*;

module uart_serial_rx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_ready,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);

  localparam logic [SW-1:0] OFF_S0  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] OFF_S1  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] OFF_DEC = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] OFF_END = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_B  = 4'(DATA_BITS - 1);

  logic s1_q;
  logic s2_q;
  logic rxd_s;

  rx_state_e            state_q;
  logic [SW-1:0]        scnt_q;
  logic [3:0]           bcnt_q;
  logic [1:0]           smp_q;
  logic [DATA_BITS-1:0] shr_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 rdy_q;
  logic                 vld_q;
  logic                 ferr_q;
  logic                 ovr_q;

  logic tick;
  logic start_go;
  logic sampling;
  logic maj;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= rxd;
      s2_q <= s1_q;
    end
  end

  assign rxd_s = s2_q;

  // Restart the tick phase on the detected start edge.
  assign start_go = (state_q == ST_IDLE) && !rxd_s;

  uart_baud_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk_i (clk),
    .rst_ni(rst),
    .clr_i (start_go),
    .tick_o(tick)
  );

  assign sampling = (state_q == ST_START) ||
                    (state_q == ST_DATA)  ||
                    (state_q == ST_STOP);

  // Third vote is the live sample taken at the decision tick.
  assign maj = (smp_q[0] & smp_q[1]) |
               (smp_q[0] & rxd_s)    |
               (smp_q[1] & rxd_s);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      smp_q   <= '0;
      shr_q   <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      rdy_q  <= 1'b0;
      ferr_q <= 1'b0;

      if (rx_ack) begin
        vld_q <= 1'b0;
        ovr_q <= 1'b0;
      end

      if (tick && sampling) begin
        if (scnt_q == OFF_S0) smp_q[0] <= rxd_s;
        if (scnt_q == OFF_S1) smp_q[1] <= rxd_s;
        scnt_q <= (scnt_q == OFF_END) ? '0 : scnt_q + SW'(1);
      end

      unique case (state_q)
        ST_IDLE: begin
          scnt_q <= '0;
          bcnt_q <= '0;
          if (!rxd_s) state_q <= ST_START;
        end
        ST_START: begin
          if (tick) begin
            if (scnt_q == OFF_DEC && maj) begin
              state_q <= ST_IDLE;
            end else if (scnt_q == OFF_END) begin
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (scnt_q == OFF_DEC) begin
              shr_q <= {maj, shr_q[DATA_BITS-1:1]};
            end
            if (scnt_q == OFF_END) begin
              if (bcnt_q == LAST_B) state_q <= ST_STOP;
              else bcnt_q <= bcnt_q + 4'd1;
            end
          end
        end
        ST_STOP: begin
          if (tick && scnt_q == OFF_DEC) begin
            if (maj) begin
              data_q <= shr_q;
              rdy_q  <= 1'b1;
              vld_q  <= 1'b1;
              // A simultaneous ack consumes the old byte: no overrun.
              if (vld_q && !rx_ack) ovr_q <= 1'b1;
              // Leave half a bit early so a zero-gap frame is caught.
              state_q <= ST_IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (rxd_s) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_out   = data_q;
  assign data_ready = rdy_q;
  assign rx_valid   = vld_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_serial_rx.sv
// tb_uart_serial_rx: vector table, directed corners, random frames.
// Expected bytes come from the frames the bench itself builds.
module tb_uart_serial_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] data_out;
  logic       data_ready;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  uart_serial_rx #(
    .CLK_FREQ  (1600),
    .BAUD      (100),
    .OVERSAMPLE(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .data_out  (data_out),
    .data_ready(data_ready),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_e = 0;
  int fe_cnt = 0;
  logic [7:0] got_q[$];
  int rdy_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (data_ready) begin
        got_q.push_back(data_out);
        rdy_cyc_q.push_back(cyc);
      end
      if (frame_err) fe_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    step(1);
    rx_ack = 1'b0;
  endtask

  // Drives one 8N1 frame, 16 clocks per bit, optionally forcing the
  // line low for gl clocks from offset go of bit gb, and optionally
  // stopping after nclk clocks.
  task automatic send_frame(input logic [7:0] d, input bit stop,
                            input int gb, input int go,
                            input int gl, input int nclk);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    last_e = cyc + 1;
    for (int i = 0; i < nclk; i++) begin
      int b;
      int o;
      b = i / 16;
      o = i % 16;
      if (b == gb && o >= go && o < go + gl) rxd = 1'b0;
      else rxd = fr[b];
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [7:0] d;
    int         gb;
    int         go;
    int         gl;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int n0;
    int fe0;
    int w;
    int good;
    int bad;
    logic [7:0] mdl_data;
    logic [7:0] exp_q[$];

    // Sample points land on line offsets 8, 9, 10 of each bit.
    tbl[0] = '{8'hA5, -1, 0, 0, 8'hA5};
    tbl[1] = '{8'h04, 3, 6, 3, 8'h04};
    tbl[2] = '{8'h5B, 1, 9, 1, 8'h5B};
    tbl[3] = '{8'hC9, 4, 10, 1, 8'hC9};

    #1;
    chk("rst_data_out", data_out, 0);
    chk("rst_flags", {data_ready, rx_valid, frame_err, overrun, busy}, 0);
    step(3);
    rst = 1'b1;
    step(5);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 4; i++) begin
      ack_pulse();
      n0 = got_q.size();
      fe0 = fe_cnt;
      send_frame(tbl[i].d, 1'b1, tbl[i].gb, tbl[i].go, tbl[i].gl, 160);
      rxd = 1'b1;
      step(8);
      chk("tbl_pulses", got_q.size() - n0, 1);
      chk("tbl_data_out", data_out, tbl[i].exp);
      chk("tbl_rx_valid", rx_valid, 1);
      chk("tbl_frame_err", fe_cnt - fe0, 0);
      if (i == 0 && rdy_cyc_q.size() > 0) begin
        chk("latency", rdy_cyc_q[rdy_cyc_q.size()-1] - last_e, 156);
      end
    end

    // Back-to-back, zero idle gap, no ack.
    ack_pulse();
    n0 = got_q.size();
    send_frame(8'h00, 1'b1, -1, 0, 0, 160);
    send_frame(8'hFF, 1'b1, -1, 0, 0, 160);
    rxd = 1'b1;
    step(8);
    chk("b2b_pulses", got_q.size() - n0, 2);
    if (got_q.size() >= n0 + 2) begin
      chk("b2b_first", got_q[n0], 8'h00);
      chk("b2b_second", got_q[n0+1], 8'hFF);
      chk("b2b_spacing", rdy_cyc_q[n0+1] - rdy_cyc_q[n0], 160);
    end
    chk("b2b_data_out", data_out, 8'hFF);
    chk("b2b_overrun", overrun, 1);
    chk("b2b_rx_valid", rx_valid, 1);
    ack_pulse();
    chk("ack_rx_valid", rx_valid, 0);
    chk("ack_overrun", overrun, 0);

    // Four-clock low glitch: false start.
    n0 = got_q.size();
    rxd = 1'b0;
    step(4);
    chk("fs_busy_hi", busy, 1);
    rxd = 1'b1;
    w = 0;
    while (busy && w < 12) begin
      step(1);
      w++;
    end
    chk("fs_busy_lo", busy, 0);
    step(8);
    chk("fs_no_data", got_q.size() - n0, 0);
    send_frame(8'h3C, 1'b1, -1, 0, 0, 160);
    rxd = 1'b1;
    step(8);
    chk("fs_next_data", data_out, 8'h3C);
    chk("fs_next_pulses", got_q.size() - n0, 1);

    // Stop bit low, line held low: one frame_err, then break.
    ack_pulse();
    n0 = got_q.size();
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, -1, 0, 0, 160);
    rxd = 1'b0;
    step(500);
    chk("brk_frame_err", fe_cnt - fe0, 1);
    chk("brk_busy", busy, 1);
    chk("brk_data_out", data_out, 8'h3C);
    chk("brk_rx_valid", rx_valid, 0);
    chk("brk_no_data", got_q.size() - n0, 0);
    rxd = 1'b1;
    step(4);
    chk("brk_idle", busy, 0);

    // Reset during data bit 4.
    send_frame(8'hAA, 1'b1, -1, 0, 0, 5 * 16 + 8);
    rst = 1'b0;
    #1;
    chk("mid_rst_data_out", data_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_flags", {data_ready, rx_valid, frame_err, overrun}, 0);
    rxd = 1'b1;
    step(3);
    rst = 1'b1;
    step(20);
    chk("post_rst_busy", busy, 0);

    // Ack high on the load edge: byte wins, no overrun.
    fork
      send_frame(8'h81, 1'b1, -1, 0, 0, 160);
      begin
        repeat (156) @(posedge clk);
        #1 rx_ack = 1'b1;
        @(posedge clk);
        #1 rx_ack = 1'b0;
      end
    join
    rxd = 1'b1;
    step(8);
    chk("ack_same_data", data_out, 8'h81);
    chk("ack_same_valid", rx_valid, 1);
    chk("ack_same_ovr", overrun, 0);
    fork
      send_frame(8'h7E, 1'b1, -1, 0, 0, 160);
      begin
        repeat (156) @(posedge clk);
        #1 rx_ack = 1'b1;
        @(posedge clk);
        #1 rx_ack = 1'b0;
      end
    join
    rxd = 1'b1;
    step(8);
    chk("ack_same2_data", data_out, 8'h7E);
    chk("ack_same2_valid", rx_valid, 1);
    chk("ack_same2_ovr", overrun, 0);

    // Random frames against the frame-level model.
    ack_pulse();
    n0 = got_q.size();
    fe0 = fe_cnt;
    good = 0;
    bad = 0;
    mdl_data = 8'h7E;
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      bit stop;
      int gb;
      int go;
      int gap;
      d = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 5) != 0);
      gb = -1;
      go = 0;
      if ($urandom_range(0, 1) == 1) begin
        gb = $urandom_range(1, 8);
        go = $urandom_range(0, 15);
      end
      send_frame(d, stop, gb, go, 1, 160);
      if (stop) begin
        exp_q.push_back(d);
        good++;
        mdl_data = d;
        gap = $urandom_range(0, 12);
      end else begin
        bad++;
        gap = $urandom_range(3, 12);
      end
      rxd = 1'b1;
      if (gap > 0) step(gap);
    end
    step(8);
    chk("rnd_count", got_q.size() - n0, good);
    for (int j = 0; j < exp_q.size(); j++) begin
      if (n0 + j < got_q.size()) begin
        chk("rnd_byte", got_q[n0+j], exp_q[j]);
      end
    end
    chk("rnd_frame_err", fe_cnt - fe0, bad);
    chk("rnd_data_out", data_out, mdl_data);
    chk("rnd_rx_valid", rx_valid, (good > 0) ? 1 : 0);
    chk("rnd_overrun", overrun, (good > 1) ? 1 : 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
